// File: rtl/sindoku_btn_conditioner.sv
// Button front end for the SINdoku game FSM: synchronizes, debounces and
// auto-repeats six push buttons into arbitrated single-cycle enables.
//
// state | meaning
// IDLE  | button released and quiet
// WQ    | raw press seen, waiting for it to stay stable
// SCEN  | press accepted, request the first pulse
// HOLD  | held, timing toward auto-repeat (non-repeat channels just wait)
// MCEN  | request an auto-repeat pulse
// RPT   | held, timing toward the next repeat pulse
// WREL  | released, waiting for the release to stay stable
module sindoku_btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 15_000_000
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic BtnR,
    input  logic BtnL,
    input  logic BtnU,
    input  logic BtnD,
    input  logic BtnC,
    input  logic BtnCheck,
    output logic R,
    output logic L,
    output logic U,
    output logic D,
    output logic C,
    output logic CheckSolu
);

    localparam int NCH     = 6;
    localparam int MAX_A   = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);
    // Channel order: 0 R, 1 L, 2 U, 3 D, 4 C, 5 CheckSolu
    localparam logic [NCH-1:0] RPT_EN   = 6'b001111;

    typedef enum logic [2:0] {
        IDLE, WQ, SCEN, HOLD, MCEN, RPT, WREL
    } chan_state_t;

    logic [NCH-1:0] btn_raw;
    logic [NCH-1:0] s1;
    logic [NCH-1:0] s2;
    logic [NCH-1:0] req;
    logic [NCH-1:0] win;
    logic [NCH-1:0] out_q;

    chan_state_t   state     [NCH];
    chan_state_t   state_nxt [NCH];
    logic [CW-1:0] cnt       [NCH];
    logic [CW-1:0] cnt_nxt   [NCH];

    assign btn_raw = {BtnCheck, BtnC, BtnD, BtnU, BtnL, BtnR};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1    <= '0;
            s2    <= '0;
            out_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            s1    <= btn_raw;
            s2    <= s1;
            out_q <= win;
            for (int i = 0; i < NCH; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req       = '0;
        for (int i = 0; i < NCH; i++) begin
            case (state[i])
                IDLE: begin
                    cnt_nxt[i] = '0;
                    if (s2[i]) state_nxt[i] = WQ;
                end
                WQ: begin
                    if (!s2[i]) begin
                        state_nxt[i] = IDLE;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == DEB_LAST) begin
                        state_nxt[i] = SCEN;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                SCEN: begin
                    req[i]       = 1'b1;
                    state_nxt[i] = HOLD;
                    cnt_nxt[i]   = '0;
                end
                HOLD: begin
                    if (!s2[i]) begin
                        state_nxt[i] = WREL;
                        cnt_nxt[i]   = '0;
                    end else if (RPT_EN[i] && cnt[i] == HOLD_LAST) begin
                        state_nxt[i] = MCEN;
                    end else if (RPT_EN[i] || cnt[i] != '1) begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                MCEN: begin
                    req[i]       = 1'b1;
                    state_nxt[i] = RPT;
                    cnt_nxt[i]   = '0;
                end
                RPT: begin
                    if (!s2[i]) begin
                        state_nxt[i] = WREL;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == RPT_LAST) begin
                        state_nxt[i] = MCEN;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                WREL: begin
                    // A bounce back high resumes the hold without a new pulse
                    if (s2[i]) begin
                        state_nxt[i] = HOLD;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == DEB_LAST) begin
                        state_nxt[i] = IDLE;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    state_nxt[i] = IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
    end

    // Movement/enter requests are mutually exclusive: C > U > D > L > R, losers dropped
    always_comb begin
        win    = '0;
        win[5] = req[5];
        if (req[4])      win[4] = 1'b1;
        else if (req[2]) win[2] = 1'b1;
        else if (req[3]) win[3] = 1'b1;
        else if (req[1]) win[1] = 1'b1;
        else if (req[0]) win[0] = 1'b1;
    end

    assign {CheckSolu, C, D, U, L, R} = out_q;

endmodule

// File: tb/tb_sindoku_btn_conditioner.sv
// Directed bench for sindoku_btn_conditioner with small timing parameters;
// pulse edges are logged per output and compared to hand-derived edges.
module tb_sindoku_btn_conditioner;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic BtnR = 1'b0, BtnL = 1'b0, BtnU = 1'b0, BtnD = 1'b0, BtnC = 1'b0, BtnCheck = 1'b0;
    logic R, L, U, D, C, CheckSolu;
    logic [5:0] outs;

    int compared = 0;
    int mism = 0;
    int ed = 0;
    int pulse_cnt [6];
    int pulse_edge [6][16];

    sindoku_btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(16),
        .REPEAT_CYCLES(8)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .BtnR(BtnR), .BtnL(BtnL), .BtnU(BtnU), .BtnD(BtnD), .BtnC(BtnC), .BtnCheck(BtnCheck),
        .R(R), .L(L), .U(U), .D(D), .C(C), .CheckSolu(CheckSolu)
    );

    always #5 Clk = ~Clk;

    // index: 0 R, 1 L, 2 U, 3 D, 4 C, 5 CheckSolu
    assign outs = {CheckSolu, C, D, U, L, R};

    task automatic clear_log();
        ed = 0;
        for (int i = 0; i < 6; i++) begin
            pulse_cnt[i] = 0;
            for (int k = 0; k < 16; k++) pulse_edge[i][k] = -1;
        end
    endtask

    task automatic tick(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge Clk);
            #1;
            ed++;
            for (int i = 0; i < 6; i++) begin
                if (outs[i]) begin
                    if (pulse_cnt[i] < 16) pulse_edge[i][pulse_cnt[i]] = ed;
                    pulse_cnt[i]++;
                end
            end
        end
    endtask

    task automatic set_all(input logic v);
        BtnR = v; BtnL = v; BtnU = v; BtnD = v; BtnC = v; BtnCheck = v;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        set_all(1'b1);
        clear_log();
        tick(10);
        compared++;
        if ((pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5]) !== 0) begin
            mism++;
            $display("FAIL reset_quiet: pulses during reset=%0d want 0",
                     pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] + pulse_cnt[4] + pulse_cnt[5]);
        end
        compared++;
        if (outs !== 6'b0) begin
            mism++;
            $display("FAIL reset_outs: got %b want 000000", outs);
        end
        clear_log();
        Reset_n = 1'b1;
        tick(20);
        compared++;
        if (pulse_cnt[4] !== 1) begin mism++; $display("FAIL reset_c_count: got %0d want 1", pulse_cnt[4]); end
        compared++;
        if (pulse_edge[4][0] !== 8) begin mism++; $display("FAIL reset_c_edge: got %0d want 8", pulse_edge[4][0]); end
        compared++;
        if (pulse_cnt[5] !== 1) begin mism++; $display("FAIL reset_chk_count: got %0d want 1", pulse_cnt[5]); end
        compared++;
        if (pulse_edge[5][0] !== 8) begin mism++; $display("FAIL reset_chk_edge: got %0d want 8", pulse_edge[5][0]); end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (pulse_cnt[i] !== 0) begin mism++; $display("FAIL reset_dir%0d_quiet: got %0d pulses want 0", i, pulse_cnt[i]); end
        end
        set_all(1'b0);
        Reset_n = 1'b0;
        tick(2);
        Reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_reset_mid_press();
        clear_log();
        BtnCheck = 1'b1;
        tick(5);
        Reset_n = 1'b0;
        tick(2);
        Reset_n = 1'b1;
        clear_log();
        tick(12);
        compared++;
        if (pulse_cnt[5] !== 1) begin mism++; $display("FAIL midreset_count: got %0d want 1", pulse_cnt[5]); end
        compared++;
        if (pulse_edge[5][0] !== 8) begin mism++; $display("FAIL midreset_edge: got %0d want 8", pulse_edge[5][0]); end
        BtnCheck = 1'b0;
        tick(12);
    endtask

    task automatic test_check();
        clear_log();
        BtnCheck = 1'b1;
        tick(100);
        BtnCheck = 1'b0;
        tick(20);
        compared++;
        if (pulse_cnt[5] !== 1) begin mism++; $display("FAIL check_count: got %0d want 1", pulse_cnt[5]); end
        compared++;
        if (pulse_edge[5][0] !== 8) begin mism++; $display("FAIL check_edge: got %0d want 8", pulse_edge[5][0]); end
        compared++;
        if (pulse_cnt[4] !== 0) begin mism++; $display("FAIL check_c_quiet: got %0d want 0", pulse_cnt[4]); end
        clear_log();
        BtnCheck = 1'b1;
        tick(20);
        BtnCheck = 1'b0;
        tick(15);
        compared++;
        if (pulse_cnt[5] !== 1) begin mism++; $display("FAIL check_repress_count: got %0d want 1", pulse_cnt[5]); end
        compared++;
        if (pulse_edge[5][0] !== 8) begin mism++; $display("FAIL check_repress_edge: got %0d want 8", pulse_edge[5][0]); end
    endtask

    task automatic test_repeat();
        int exp_e [5] = '{8, 25, 34, 43, 52};
        clear_log();
        BtnR = 1'b1;
        tick(55);
        BtnR = 1'b0;
        tick(45);
        compared++;
        if (pulse_cnt[0] !== 5) begin mism++; $display("FAIL repeat_count: got %0d want 5", pulse_cnt[0]); end
        for (int k = 0; k < 5; k++) begin
            compared++;
            if (pulse_edge[0][k] !== exp_e[k]) begin
                mism++;
                $display("FAIL repeat_edge%0d: got %0d want %0d", k, pulse_edge[0][k], exp_e[k]);
            end
        end
    endtask

    task automatic test_bounce();
        clear_log();
        for (int r = 0; r < 10; r++) begin
            BtnU = 1'b1;
            tick(3);
            BtnU = 1'b0;
            tick(1);
        end
        compared++;
        if (pulse_cnt[2] !== 0) begin mism++; $display("FAIL bounce_quiet: got %0d want 0", pulse_cnt[2]); end
        BtnU = 1'b1;
        tick(20);
        BtnU = 1'b0;
        tick(15);
        compared++;
        if (pulse_cnt[2] !== 1) begin mism++; $display("FAIL bounce_count: got %0d want 1", pulse_cnt[2]); end
        compared++;
        if (pulse_edge[2][0] !== 48) begin mism++; $display("FAIL bounce_edge: got %0d want 48", pulse_edge[2][0]); end
    endtask

    task automatic test_arbitration();
        clear_log();
        BtnL = 1'b1;
        BtnC = 1'b1;
        tick(36);
        BtnL = 1'b0;
        BtnC = 1'b0;
        tick(14);
        compared++;
        if (pulse_cnt[4] !== 1) begin mism++; $display("FAIL arb_c_count: got %0d want 1", pulse_cnt[4]); end
        compared++;
        if (pulse_edge[4][0] !== 8) begin mism++; $display("FAIL arb_c_edge: got %0d want 8", pulse_edge[4][0]); end
        compared++;
        if (pulse_cnt[1] !== 2) begin mism++; $display("FAIL arb_l_count: got %0d want 2", pulse_cnt[1]); end
        compared++;
        if (pulse_edge[1][0] !== 25) begin mism++; $display("FAIL arb_l_edge0: got %0d want 25", pulse_edge[1][0]); end
        compared++;
        if (pulse_edge[1][1] !== 34) begin mism++; $display("FAIL arb_l_edge1: got %0d want 34", pulse_edge[1][1]); end
    endtask

    task automatic test_release_glitch();
        clear_log();
        BtnD = 1'b1;
        tick(19);
        BtnD = 1'b0;
        tick(2);
        BtnD = 1'b1;
        tick(24);
        BtnD = 1'b0;
        tick(25);
        compared++;
        if (pulse_cnt[3] !== 2) begin mism++; $display("FAIL glitch_count: got %0d want 2", pulse_cnt[3]); end
        compared++;
        if (pulse_edge[3][0] !== 8) begin mism++; $display("FAIL glitch_edge0: got %0d want 8", pulse_edge[3][0]); end
        compared++;
        if (pulse_edge[3][1] !== 41) begin mism++; $display("FAIL glitch_edge1: got %0d want 41", pulse_edge[3][1]); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_press();
        test_check();
        test_repeat();
        test_bounce();
        test_arbitration();
        test_release_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
